// File: rtl/count_watch_pkg.sv
// Shared definitions for count_watch: FSM state encoding and the upstream counter width.
package count_watch_pkg;

  localparam int Q_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRE  = 2'b10,
    ST_SPARE = 2'b11
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return (s == ST_ARMED) || (s == ST_FIRE);
  endfunction

endpackage

// File: rtl/count_watch_sat_cnt.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         cl,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  logic [W-1:0] r_count;
  logic         r_ovf;
  logic         w_full;

  assign w_full = &r_count;

  // Clear dominates increment; a request at full scale only raises the sticky flag.
  always_ff @(posedge clk) begin
    if (!cl) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_inc) begin
      if (w_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/count_watch.sv
// Watches an upstream 4-bit counter: cascades its terminal count, tallies wraps,
// and raises irq after HITS departures from match_val while armed.
module count_watch
  import count_watch_pkg::*;
#(
  parameter int HITS   = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              cl,
  input  logic              count_enable,
  input  logic [1:Q_W]      q_in,
  input  logic [1:Q_W]      match_val,
  input  logic              arm,
  input  logic              ack,
  input  logic              clr_wrap,
  output logic              carry_out,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              ovf,
  output logic              irq,
  output logic              busy
);

  localparam logic [3:0]     HITS_LAST = 4'(HITS - 1);
  localparam logic [1:Q_W]   TC_VAL    = {Q_W{1'b1}};

  logic   w_tc;
  logic   w_hit;
  state_t r_state;
  state_t w_state_next;
  logic [3:0] r_hcnt;
  logic [3:0] w_hcnt_next;

  // A hit means the counter leaves match_val on this edge.
  assign w_tc      = count_enable & (q_in == TC_VAL);
  assign w_hit     = count_enable & (q_in == match_val);
  assign carry_out = w_tc & cl;

  sat_cnt #(
    .W(WRAP_W)
  ) u_wrap (
    .clk     (clk),
    .cl      (cl),
    .i_clr   (clr_wrap),
    .i_inc   (w_tc),
    .o_count (wrap_cnt),
    .o_ovf   (ovf)
  );

  always_ff @(posedge clk) begin
    if (!cl) begin
      r_state <= ST_IDLE;
      r_hcnt  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_hcnt  <= w_hcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hcnt_next  = r_hcnt;
    case (r_state)
      ST_IDLE: begin
        w_hcnt_next = 4'd0;
        if (arm) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          w_state_next = ST_IDLE;
          w_hcnt_next  = 4'd0;
        end else if (w_hit) begin
          if (r_hcnt == HITS_LAST) begin
            w_state_next = ST_FIRE;
            w_hcnt_next  = 4'd0;
          end else begin
            w_hcnt_next = r_hcnt + 4'd1;
          end
        end
      end
      ST_FIRE: begin
        w_hcnt_next = 4'd0;
        if (ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_hcnt_next  = 4'd0;
      end
    endcase
  end

  // irq is exactly "in FIRE", so it rises one edge after the qualifying hit.
  always_comb begin
    irq  = (r_state == ST_FIRE);
    busy = state_is_busy(r_state);
  end

endmodule
